interrupt_controller: RTL and testbench

//  Owns the IF (0xFF0F) and IE (0xFFFF) registers, the IME flag and the interrupt dispatch

---
 rtl/interrupt_controller.sv | 177 +++++++++++++++++
 tb/tb_interrupt_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: IF/IE registers, IME flag and the 5-M-cycle interrupt
// dispatch sequence (WAIT0, WAIT1, PUSH_HI, PUSH_LO, JUMP), plus the HALT wake signal.
// Optional feature macro: INT_DISPATCH_CANCEL_EN re-selects the interrupt from live
// IE&IF when leaving PUSH_HI. If nothing is pending at that point, the vector is
// 16'h0000 and no IF bit is cleared. When the macro is undefined, the index latched
// at dispatch start is used instead.
module interrupt_controller #(
    parameter logic [15:0] VECTOR_BASE   = 16'h0040,
    parameter int unsigned VECTOR_STRIDE = 8,
    parameter logic [15:0] IF_ADDR       = 16'hFF0F,
    parameter logic [15:0] IE_ADDR       = 16'hFFFF
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_M_Tick,
    input  logic [4:0]  i_Int_Req,
    input  logic [15:0] i_Bus_Addr,
    input  logic        i_Bus_Wr,
    input  logic [7:0]  i_Bus_WData,
    output logic [7:0]  o_Bus_RData,
    output logic        o_Bus_Sel,
    input  logic        i_Instr_Boundary,
    input  logic        i_EI,
    input  logic        i_DI,
    input  logic        i_RETI,
    output logic        o_IME,
    output logic        o_Dispatch,
    output logic        o_Push_Hi,
    output logic        o_Push_Lo,
    output logic        o_Jump,
    output logic [15:0] o_Vector,
    output logic        o_Wake
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT0, S_WAIT1, S_PUSH_HI, S_PUSH_LO, S_JUMP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_if;
    logic [7:0]  r_ie;
    logic        r_ime;
    logic        r_ei_pend;
    logic [15:0] r_vector;

    logic        w_hit_if;
    logic        w_hit_ie;
    logic        w_wr_if;
    logic        w_wr_ie;
    logic [4:0]  w_pending;
    logic        w_start;
    logic        w_leave_hi;
    logic [2:0]  w_sel_idx;
    logic        w_sel_valid;
    logic [4:0]  w_clr_mask;

    // Lowest set bit wins; returns 0 when nothing is set (caller checks validity).
    function automatic logic [2:0] f_lowest(input logic [4:0] v);
        logic [2:0] idx;
        if (v[0])      idx = 3'd0;
        else if (v[1]) idx = 3'd1;
        else if (v[2]) idx = 3'd2;
        else if (v[3]) idx = 3'd3;
        else if (v[4]) idx = 3'd4;
        else           idx = 3'd0;
        return idx;
    endfunction

    function automatic logic [15:0] f_vector(input logic [2:0] idx);
        return VECTOR_BASE + 16'(VECTOR_STRIDE * 32'(idx));
    endfunction

    assign w_hit_if   = (i_Bus_Addr == IF_ADDR);
    assign w_hit_ie   = (i_Bus_Addr == IE_ADDR);
    assign w_wr_if    = i_Bus_Wr && w_hit_if;
    assign w_wr_ie    = i_Bus_Wr && w_hit_ie;
    assign w_pending  = r_ie[4:0] & r_if;
    assign w_start    = i_M_Tick && i_Instr_Boundary && r_ime && (|w_pending) && (r_state == S_IDLE);
    assign w_leave_hi = i_M_Tick && (r_state == S_PUSH_HI);

`ifdef INT_DISPATCH_CANCEL_EN
    assign w_sel_idx   = f_lowest(w_pending);
    assign w_sel_valid = |w_pending;
`else
    logic [2:0] r_idx;

    // Capture the winning index on the tick that enters WAIT0.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)      r_idx <= '0;
        else if (w_start) r_idx <= f_lowest(w_pending);
    end

    assign w_sel_idx   = r_idx;
    assign w_sel_valid = 1'b1;
`endif

    assign w_clr_mask = (w_leave_hi && w_sel_valid) ? (5'b00001 << w_sel_idx) : '0;

    // IF latches requests every clock; a request beats both a bus write and the dispatch clear.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) r_if <= '0;
        else         r_if <= ((w_wr_if ? i_Bus_WData[4:0] : r_if) & ~w_clr_mask) | i_Int_Req;
    end

    // IE keeps all 8 written bits; only [4:0] take part in selection.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)      r_ie <= '0;
        else if (w_wr_ie) r_ie <= i_Bus_WData;
    end

    // IME / EI-delay: EI arms a pending flag promoted at the next boundary tick, DI wins at once.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_ime     <= 1'b0;
            r_ei_pend <= 1'b0;
        end else if (w_start || i_DI) begin
            r_ime     <= 1'b0;
            r_ei_pend <= 1'b0;
        end else begin
            if (i_RETI) r_ime <= 1'b1;
            if (i_M_Tick && i_Instr_Boundary && r_ei_pend) begin
                r_ime     <= 1'b1;
                r_ei_pend <= 1'b0;
            end
            // Set after the promotion so an EI on a boundary tick waits for the next one.
            if (i_EI) r_ei_pend <= 1'b1;
        end
    end

    // Vector register, loaded on the tick leaving PUSH_HI.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)         r_vector <= '0;
        else if (w_leave_hi) r_vector <= w_sel_valid ? f_vector(w_sel_idx) : 16'h0000;
    end

    // Dispatch FSM state register.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Next state: one step per M-tick once started.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start)  w_state_next = S_WAIT0;
            S_WAIT0:   if (i_M_Tick) w_state_next = S_WAIT1;
            S_WAIT1:   if (i_M_Tick) w_state_next = S_PUSH_HI;
            S_PUSH_HI: if (i_M_Tick) w_state_next = S_PUSH_LO;
            S_PUSH_LO: if (i_M_Tick) w_state_next = S_JUMP;
            S_JUMP:    if (i_M_Tick) w_state_next = S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    // Moore strobes decoded from the state.
    always_comb begin
        o_Dispatch = (r_state != S_IDLE);
        o_Push_Hi  = (r_state == S_PUSH_HI);
        o_Push_Lo  = (r_state == S_PUSH_LO);
        o_Jump     = (r_state == S_JUMP);
    end

    // Bus read mux; unused IF bits read as 1.
    always_comb begin
        o_Bus_RData = 8'h00;
        if (w_hit_if)      o_Bus_RData = {3'b111, r_if};
        else if (w_hit_ie) o_Bus_RData = r_ie;
    end

    assign o_Bus_Sel = w_hit_if || w_hit_ie;
    assign o_IME     = r_ime;
    assign o_Vector  = r_vector;
    assign o_Wake    = |w_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: register-access vector table plus
// hand-written dispatch, EI-delay, cancel and mid-dispatch reset sequences.
module tb_interrupt_controller;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_M_Tick = 1'b0;
    logic [4:0]  i_Int_Req = '0;
    logic [15:0] i_Bus_Addr = '0;
    logic        i_Bus_Wr = 1'b0;
    logic [7:0]  i_Bus_WData = '0;
    logic [7:0]  o_Bus_RData;
    logic        o_Bus_Sel;
    logic        i_Instr_Boundary = 1'b0;
    logic        i_EI = 1'b0;
    logic        i_DI = 1'b0;
    logic        i_RETI = 1'b0;
    logic        o_IME;
    logic        o_Dispatch;
    logic        o_Push_Hi;
    logic        o_Push_Lo;
    logic        o_Jump;
    logic [15:0] o_Vector;
    logic        o_Wake;

    int npass = 0;
    int ntotal = 0;

    localparam logic [15:0] A_IF = 16'hFF0F;
    localparam logic [15:0] A_IE = 16'hFFFF;

    interrupt_controller #(
        .VECTOR_BASE(16'h0040), .VECTOR_STRIDE(8), .IF_ADDR(16'hFF0F), .IE_ADDR(16'hFFFF)
    ) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_M_Tick(i_M_Tick), .i_Int_Req(i_Int_Req),
        .i_Bus_Addr(i_Bus_Addr), .i_Bus_Wr(i_Bus_Wr), .i_Bus_WData(i_Bus_WData),
        .o_Bus_RData(o_Bus_RData), .o_Bus_Sel(o_Bus_Sel), .i_Instr_Boundary(i_Instr_Boundary),
        .i_EI(i_EI), .i_DI(i_DI), .i_RETI(i_RETI), .o_IME(o_IME), .o_Dispatch(o_Dispatch),
        .o_Push_Hi(o_Push_Hi), .o_Push_Lo(o_Push_Lo), .o_Jump(o_Jump), .o_Vector(o_Vector),
        .o_Wake(o_Wake)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [15:0] wr_addr;
        logic        wr;
        logic [7:0]  wdata;
        logic [4:0]  req;
        logic [15:0] rd_addr;
        logic [7:0]  exp_rd;
        logic        exp_sel;
        logic        exp_wake;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        ntotal++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else             npass++;
    endtask

    // One clock; single-clock strobes are dropped afterwards, inputs change at posedge+1.
    task automatic cyc();
        @(posedge i_Clk);
        #1;
        i_Bus_Wr = 1'b0; i_Int_Req = '0; i_EI = 1'b0; i_DI = 1'b0; i_RETI = 1'b0;
        i_M_Tick = 1'b0; i_Instr_Boundary = 1'b0;
    endtask

    // M-tick followed by an idle clock, so state must hold between ticks.
    task automatic mtick(input logic boundary);
        i_M_Tick = 1'b1; i_Instr_Boundary = boundary;
        cyc();
        cyc();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        i_Bus_Addr = a; i_Bus_Wr = 1'b1; i_Bus_WData = d;
        cyc();
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [7:0] exp);
        i_Bus_Addr = a;
        #1;
        chk(name, 16'(o_Bus_RData), 16'(exp));
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        cyc();
        cyc();
        i_Reset = 1'b0;
        cyc();
    endtask

    // Reset, then IE=ie, request bits req, and IME=1 via RETI.
    task automatic setup(input logic [7:0] ie, input logic [4:0] req);
        do_reset();
        wr(A_IE, ie);
        i_Int_Req = req; cyc();
        i_RETI = 1'b1; cyc();
    endtask

    initial begin
        // addr, wr, data, req -> read addr, exp data, exp sel, exp wake
        vecs[0] = '{16'h0000, 1'b0, 8'h00, 5'b00000, A_IF,     8'hE0, 1'b1, 1'b0};
        vecs[1] = '{16'h0000, 1'b0, 8'h00, 5'b00000, A_IE,     8'h00, 1'b1, 1'b0};
        vecs[2] = '{A_IF,     1'b1, 8'h00, 5'b00100, A_IF,     8'hE4, 1'b1, 1'b0};
        vecs[3] = '{A_IE,     1'b1, 8'h04, 5'b00000, A_IE,     8'h04, 1'b1, 1'b1};
        vecs[4] = '{A_IF,     1'b1, 8'hFF, 5'b00000, A_IF,     8'hFF, 1'b1, 1'b1};
        vecs[5] = '{A_IE,     1'b1, 8'hE0, 5'b00000, A_IE,     8'hE0, 1'b1, 1'b0};
        vecs[6] = '{A_IF,     1'b1, 8'h00, 5'b10000, A_IF,     8'hF0, 1'b1, 1'b0};
        vecs[7] = '{A_IE,     1'b1, 8'h10, 5'b00000, 16'h1234, 8'h00, 1'b0, 1'b1};
        vecs[8] = '{16'h1234, 1'b1, 8'hAA, 5'b00000, A_IF,     8'hF0, 1'b1, 1'b1};
        vecs[9] = '{A_IF,     1'b1, 8'h03, 5'b00100, A_IF,     8'hE7, 1'b1, 1'b0};

        // Reset state
        do_reset();
        chk("rst_ime", 16'(o_IME), 16'h0);
        chk("rst_dispatch", 16'(o_Dispatch), 16'h0);
        chk("rst_wake", 16'(o_Wake), 16'h0);
        chk("rst_vector", o_Vector, 16'h0000);

        // Register access table (IME stays 0, no ticks)
        for (int i = 0; i < 10; i++) begin
            i_Bus_Addr = vecs[i].wr_addr; i_Bus_Wr = vecs[i].wr;
            i_Bus_WData = vecs[i].wdata; i_Int_Req = vecs[i].req;
            cyc();
            i_Bus_Addr = vecs[i].rd_addr;
            #1;
            chk($sformatf("vec%0d_rdata", i), 16'(o_Bus_RData), 16'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_sel", i), 16'(o_Bus_Sel), 16'(vecs[i].exp_sel));
            chk($sformatf("vec%0d_wake", i), 16'(o_Wake), 16'(vecs[i].exp_wake));
        end

        // Wake with IME=0 never dispatches
        do_reset();
        wr(A_IE, 8'h04);
        i_Int_Req = 5'b00100; cyc();
        mtick(1'b1); mtick(1'b1);
        chk("wake_ime0", 16'(o_Wake), 16'h1);
        chk("nodisp_ime0", 16'(o_Dispatch), 16'h0);

        // Basic dispatch: two requests, lower index (1) wins
        setup(8'h1F, 5'b00110);
        chk("d_ime_set", 16'(o_IME), 16'h1);
        rd("d_if_pre", A_IF, 8'hE6);
        mtick(1'b1);
        chk("d_wait0_disp", 16'(o_Dispatch), 16'h1);
        chk("d_wait0_ime", 16'(o_IME), 16'h0);
        chk("d_wait0_hi", 16'(o_Push_Hi), 16'h0);
        mtick(1'b0);
        chk("d_wait1_hi", 16'(o_Push_Hi), 16'h0);
        mtick(1'b0);
        chk("d_pushhi", 16'(o_Push_Hi), 16'h1);
        rd("d_if_hi", A_IF, 8'hE6);
        mtick(1'b0);
        chk("d_pushlo", 16'(o_Push_Lo), 16'h1);
        chk("d_vec_lo", o_Vector, 16'h0048);
        rd("d_if_lo", A_IF, 8'hE4);
        mtick(1'b0);
        chk("d_jump", 16'(o_Jump), 16'h1);
        chk("d_vec_jump", o_Vector, 16'h0048);
        mtick(1'b1);
        chk("d_idle", 16'(o_Dispatch), 16'h0);
        chk("d_ime_after", 16'(o_IME), 16'h0);
        rd("d_if_after", A_IF, 8'hE4);

        // Timer (bit 2) alone: vector 0x0050
        setup(8'h1F, 5'b00100);
        mtick(1'b1); mtick(1'b0); mtick(1'b0); mtick(1'b0);
        chk("t_vec", o_Vector, 16'h0050);
        rd("t_if", A_IF, 8'hE0);

        // EI delay: one boundary tick to enable, dispatch on the following one
        do_reset();
        wr(A_IE, 8'h01);
        i_Int_Req = 5'b00001; cyc();
        i_EI = 1'b1; cyc();
        chk("ei_ime_pend", 16'(o_IME), 16'h0);
        mtick(1'b1);
        chk("ei_n1_nodisp", 16'(o_Dispatch), 16'h0);
        chk("ei_n1_ime", 16'(o_IME), 16'h1);
        mtick(1'b1);
        chk("ei_n2_disp", 16'(o_Dispatch), 16'h1);

        // EI and DI in the same clock: DI wins
        do_reset();
        wr(A_IE, 8'h01);
        i_Int_Req = 5'b00001; cyc();
        i_EI = 1'b1; i_DI = 1'b1; cyc();
        mtick(1'b1); mtick(1'b1); mtick(1'b1);
        chk("eidi_nodisp", 16'(o_Dispatch), 16'h0);
        chk("eidi_ime", 16'(o_IME), 16'h0);

        // DI clears IME immediately
        setup(8'h00, 5'b00000);
        i_DI = 1'b1; cyc();
        chk("di_clear", 16'(o_IME), 16'h0);

        // IE cleared while in PUSH_HI
        setup(8'h01, 5'b00001);
        mtick(1'b1); mtick(1'b0); mtick(1'b0);
        chk("c_pushhi", 16'(o_Push_Hi), 16'h1);
        wr(A_IE, 8'h00);
        mtick(1'b0);
        chk("c_pushlo", 16'(o_Push_Lo), 16'h1);
`ifdef INT_DISPATCH_CANCEL_EN
        chk("c_vec", o_Vector, 16'h0000);
        rd("c_if", A_IF, 8'hE1);
`else
        chk("c_vec", o_Vector, 16'h0040);
        rd("c_if", A_IF, 8'hE0);
`endif

        // Reset during PUSH_LO
        setup(8'h1F, 5'b00001);
        mtick(1'b1); mtick(1'b0); mtick(1'b0); mtick(1'b0);
        chk("r_pushlo", 16'(o_Push_Lo), 16'h1);
        chk("r_vec_pre", o_Vector, 16'h0040);
        i_Reset = 1'b1;
        cyc();
        chk("r_disp", 16'(o_Dispatch), 16'h0);
        chk("r_lo", 16'(o_Push_Lo), 16'h0);
        chk("r_vec", o_Vector, 16'h0000);
        chk("r_ime", 16'(o_IME), 16'h0);
        rd("r_if", A_IF, 8'hE0);
        rd("r_ie", A_IE, 8'h00);
        i_Reset = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
